// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: pause vector
// encodings (contiguous low-order runs of ones) and controller state codes.
package pipe_ctrl_pkg;

  localparam int PAUSE_W = 6;

  localparam logic [PAUSE_W-1:0] PAUSE_NONE = 6'b000000;
  localparam logic [PAUSE_W-1:0] PAUSE_IF   = 6'b000011;
  localparam logic [PAUSE_W-1:0] PAUSE_ID   = 6'b000111;
  localparam logic [PAUSE_W-1:0] PAUSE_EX   = 6'b001111;
  localparam logic [PAUSE_W-1:0] PAUSE_MEM  = 6'b011111;

  localparam logic [1:0] CTRL_IDLE     = 2'd0;
  localparam logic [1:0] CTRL_FLUSH    = 2'd1;
  localparam logic [1:0] CTRL_REDIRECT = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Parameterised saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central stall/flush controller: merges stage stall requests into the pause
// vector, sequences exception flushes and offers the PC redirect to fetch.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               ex_stall_req,
  input  logic               mem_stall_req,
  input  logic               excp_req,
  input  logic [ADDR_W-1:0]  excp_target,
  input  logic               redirect_ready,
  output logic [PAUSE_W-1:0] pause,
  output logic               flush,
  output logic               redirect_valid,
  output logic [ADDR_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic [1:0]         state_dbg
);

  // Redirect handshake: redirect_valid/redirect_pc are held from the cycle
  // after excp_req until the cycle redirect_ready is seen high; the transfer
  // completes on that edge and redirect_valid is low the cycle after.

  logic [1:0]         state_d, state_q;
  logic [ADDR_W-1:0]  redirect_pc_d, redirect_pc_q;
  logic [PAUSE_W-1:0] stall_enc;
  logic [PAUSE_W-1:0] pause_c;

  always_comb begin
    if (mem_stall_req)     stall_enc = PAUSE_MEM;
    else if (ex_stall_req) stall_enc = PAUSE_EX;
    else if (id_stall_req) stall_enc = PAUSE_ID;
    else if (if_stall_req) stall_enc = PAUSE_IF;
    else                   stall_enc = PAUSE_NONE;
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    pause_c       = PAUSE_NONE;
    case (state_q)
      CTRL_IDLE: begin
        // The exception only steers the transition; this cycle's pause still
        // honours the stall requests.
        pause_c = stall_enc;
        if (excp_req) begin
          state_d       = CTRL_FLUSH;
          redirect_pc_d = excp_target;
        end
      end
      CTRL_FLUSH: begin
        pause_c = PAUSE_NONE;
        state_d = redirect_ready ? CTRL_IDLE : CTRL_REDIRECT;
      end
      CTRL_REDIRECT: begin
        pause_c = PAUSE_IF;
        if (redirect_ready) state_d = CTRL_IDLE;
      end
      default: begin
        pause_c = PAUSE_NONE;
        state_d = CTRL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= CTRL_IDLE;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Stages see no hold while reset is asserted even if requests are high.
  assign pause          = rst ? pause_c : PAUSE_NONE;
  assign flush          = (state_q == CTRL_FLUSH);
  assign redirect_valid = (state_q != CTRL_IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign state_dbg      = state_q;

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (pause != PAUSE_NONE),
    .cnt   (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, each cycle
// checked against a behavioural model of the controller's rules.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_stall_req = 1'b0;
  logic              id_stall_req = 1'b0;
  logic              ex_stall_req = 1'b0;
  logic              mem_stall_req = 1'b0;
  logic              excp_req = 1'b0;
  logic [ADDR_W-1:0] excp_target = '0;
  logic              redirect_ready = 1'b0;
  logic [5:0]        pause;
  logic              flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  stall_cycles;
  logic [1:0]        state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model: mode 0 = idle, 1 = flushing, 2 = waiting for redirect accept.
  int          m_mode = 0;
  logic [31:0] m_pc   = '0;
  logic [31:0] m_cnt  = '0;

  always #5 clk = ~clk;

  pipe_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_stall_req   (if_stall_req),
    .id_stall_req   (id_stall_req),
    .ex_stall_req   (ex_stall_req),
    .mem_stall_req  (mem_stall_req),
    .excp_req       (excp_req),
    .excp_target    (excp_target),
    .redirect_ready (redirect_ready),
    .pause          (pause),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles),
    .state_dbg      (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_pause(input logic [3:0] st);
    int level;
    if (m_mode == 1) return 32'd0;
    if (m_mode == 2) return 32'd3;
    level = st[3] ? 4 : st[2] ? 3 : st[1] ? 2 : st[0] ? 1 : 0;
    return (level == 0) ? 32'd0 : ((32'd1 << (level + 1)) - 32'd1);
  endfunction

  // Called at a falling edge: drive, check, advance the model, wait one cycle.
  // st = {mem, ex, id, if} stall requests.
  task automatic cycle(input logic [3:0] st, input logic ex, input logic [31:0] tgt,
                       input logic rdy);
    logic [31:0] exp_pause;
    {mem_stall_req, ex_stall_req, id_stall_req, if_stall_req} = st;
    excp_req       = ex;
    excp_target    = tgt;
    redirect_ready = rdy;
    #1;
    if (!rst) begin
      m_mode = 0; m_pc = '0; m_cnt = '0;
    end
    exp_pause = rst ? model_pause(st) : 32'd0;
    check("pause",          32'(pause),          exp_pause);
    check("flush",          32'(flush),          32'(m_mode == 1));
    check("redirect_valid", 32'(redirect_valid), 32'(m_mode != 0));
    check("redirect_pc",    redirect_pc,         m_pc);
    check("stall_cycles",   stall_cycles,        m_cnt);
    if (rst) begin
      if (exp_pause != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      case (m_mode)
        0: if (ex) begin m_mode = 1; m_pc = tgt; end
        1: m_mode = rdy ? 0 : 2;
        default: if (rdy) m_mode = 0;
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset held with every stall request high.
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, '0, 1'b0);
    check("reset_state", 32'(state_dbg), 32'(CTRL_IDLE));
    rst = 1'b1;
    cycle(4'b0000, 1'b0, '0, 1'b0);

    // id + ex together: ex wins, four stalled cycles counted.
    for (int i = 0; i < 4; i++) cycle(4'b0110, 1'b0, '0, 1'b0);
    check("prio_count", stall_cycles, 32'd4);

    // Exception accepted immediately.
    cycle(4'b0000, 1'b1, 32'h1C00_8000, 1'b1);
    cycle(4'b0000, 1'b0, '0, 1'b1);
    cycle(4'b0000, 1'b0, '0, 1'b1);

    // Exception with the redirect held off for three REDIRECT cycles.
    cycle(4'b0000, 1'b1, 32'h1C00_8000, 1'b0);
    cycle(4'b0000, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b0, '0, 1'b0);
    cycle(4'b0000, 1'b0, '0, 1'b1);
    cycle(4'b0000, 1'b0, '0, 1'b0);
    check("delayed_count", stall_cycles, 32'd8);

    // Exception during a mem stall; a second one in REDIRECT is dropped.
    cycle(4'b1000, 1'b1, 32'h0000_A000, 1'b0);
    cycle(4'b1000, 1'b0, '0, 1'b0);
    cycle(4'b0000, 1'b1, 32'h0000_B000, 1'b0);
    cycle(4'b0000, 1'b0, '0, 1'b1);
    cycle(4'b0000, 1'b0, '0, 1'b0);

    // Saturation from all-ones minus one.
    force dut.u_cnt.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_cnt.cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    for (int i = 0; i < 5; i++) cycle(4'b1000, 1'b0, '0, 1'b0);
    cycle(4'b0000, 1'b0, '0, 1'b0);
    check("saturated", stall_cycles, 32'hFFFF_FFFF);

    // Reset while waiting in REDIRECT.
    cycle(4'b0000, 1'b1, 32'h1C00_0100, 1'b0);
    cycle(4'b0000, 1'b0, '0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_valid", 32'(redirect_valid), 32'd0);
    check("midreset_state", 32'(state_dbg), 32'(CTRL_IDLE));
    m_mode = 0; m_pc = '0; m_cnt = '0;
    @(negedge clk);
    cycle(4'b0000, 1'b0, '0, 1'b1);
    rst = 1'b1;
    cycle(4'b0000, 1'b0, '0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0), $urandom,
            1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall and flush controller for the 5-stage core.
- Merges per-stage stall requests into the 6-bit pause vector consumed by the PC register and by every stage-boundary register (if_id, id_ex, ex_mem, mem_wb).
- Sequences exception flushes and drives the PC redirect handshake toward the fetch stage.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- PAUSE_W, 6, pause vector width. bit0 = PC, bit1 = IF/ID, bit2 = ID/EX, bit3 = EX/MEM, bit4 = MEM/WB, bit5 = WB.
- ADDR_W, 32, redirect address width.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- if_stall_req  in  1  fetch stage needs more cycles.
- id_stall_req  in  1  decode stage load-use or operand hazard.
- ex_stall_req  in  1  multi-cycle ALU op (mul/div) busy.
- mem_stall_req  in  1  data memory not ready.
- excp_req  in  1  exception or ertn committed from the MEM stage; single-cycle pulse.
- excp_target  in  ADDR_W  handler or return PC for that exception.
- redirect_ready  in  1  fetch accepts the redirect this cycle.
- pause  out  PAUSE_W  stage hold vector.
- flush  out  1  clear all stage-boundary registers this cycle.
- redirect_valid  out  1  redirect PC offered to fetch.
- redirect_pc  out  ADDR_W  new fetch PC.
- stall_cycles  out  CNT_W  count of cycles with pause != 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - pause = 0, flush = 0, redirect_valid = 0, redirect_pc = 0, stall_cycles = 0.
- Pause encoding (combinational, IDLE only). The highest-indexed requester wins:
  - mem_stall_req -> 6'b011111
  - ex_stall_req -> 6'b001111
  - id_stall_req -> 6'b000111
  - if_stall_req -> 6'b000011
  - none -> 6'b000000
- Stage-register contract:
  - A boundary register with pause[i] = 1 and pause[i+1] = 0 inserts a bubble.
  - A boundary register with pause[i] = 1 and pause[i+1] = 1 holds its value.
  - The encoding must only produce contiguous low-order runs of ones.
- State machine, IDLE:
  - pause follows the encoding above.
  - On excp_req, capture excp_target into redirect_pc and go to FLUSH.
  - excp_req overrides any stall request for the state transition only. The pause value in that cycle still follows the stall requests.
- State machine, FLUSH (exactly 1 cycle):
  - flush = 1, pause = 0, redirect_valid = 1.
  - If redirect_ready = 1, go to IDLE. Otherwise go to REDIRECT.
- State machine, REDIRECT:
  - flush = 0, pause = 6'b000011 (hold the PC, bubble IF/ID), redirect_valid = 1.
  - redirect_pc stays stable.
  - On redirect_ready = 1, go to IDLE. redirect_valid drops the following cycle.
- Outside IDLE:
  - All stall requests are ignored.
  - excp_req is ignored; the pipeline is empty, so a new request is a protocol error and is dropped.
- redirect_valid and redirect_pc are registered (driven from state and the capture register).
- flush is decoded from state; there is no combinational path from excp_req to flush.
- stall_cycles:
  - Increments by 1 on every clk edge where pause != 0.
  - Saturates at all-ones and never wraps.
  - FLUSH cycles do not count; REDIRECT cycles do.
- Reset in the middle of a flush or redirect returns to IDLE immediately. Any pending redirect is lost.

Decomposition:
- Shared define file gets:
  - PAUSE_W
  - the pause constants PAUSE_NONE, PAUSE_IF, PAUSE_ID, PAUSE_EX, PAUSE_MEM
  - the state encodings CTRL_IDLE, CTRL_FLUSH, CTRL_REDIRECT
- One natural sub-module: sat_counter. It is a parameterised-width saturating up-counter with enable, and the debug counters elsewhere will reuse it.
- The FSM and the pause encoder stay inline.

Test Plan:
- Reset behaviour: hold rst = 0 for 3 cycles with all stall requests = 1 -> pause = 0, flush = 0, redirect_valid = 0, stall_cycles = 0.
- Priority encoding: id_stall_req = 1 and ex_stall_req = 1 together for 4 cycles -> pause = 6'b001111 on each of those cycles, and stall_cycles = 4 afterwards.
- Exception with immediate accept: excp_req = 1 with excp_target = 32'h1C008000, redirect_ready tied to 1 ->
  - next cycle: flush = 1, pause = 0, redirect_valid = 1, redirect_pc = 32'h1C008000;
  - following cycle: back in IDLE with redirect_valid = 0.
- Exception with delayed accept: same exception, redirect_ready = 0 for 3 cycles ->
  - 1 FLUSH cycle, then 3 REDIRECT cycles with pause = 6'b000011 and redirect_pc stable;
  - returns to IDLE the cycle after redirect_ready = 1;
  - stall_cycles grows by 4 (3 waiting cycles plus the accepting cycle; the FLUSH cycle does not count).
- Exception during a stall: excp_req = 1 while mem_stall_req = 1 -> pause = 6'b011111 in that cycle, FLUSH next cycle. A second excp_req during REDIRECT is ignored and redirect_pc is unchanged.
- Saturation and mid-flush reset:
  - Preload the counter to CNT_W'(-2) via a force and stall 5 cycles -> stall_cycles = 32'hFFFFFFFF and holds.
  - Assert rst = 0 during REDIRECT -> redirect_valid drops asynchronously and the state is IDLE.
